multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The master side is the controller, and the slave side is the datapath.
interface multicycle_controller_if;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  funct;
  logic             zero;
  logic             mem_ready;
  logic             pcen;
  logic             irwrite;
  logic             regwrite;
  logic             memwrite;
  logic             iord;
  logic             memtoreg;
  logic             regdst;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [ALU_W-1:0] alucontrol;
  logic             illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset controller. It decodes outputs from the FSM state, and it
// sets a sticky illegal-instruction flag that holds until reset.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master dp_io
);
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYP = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_e;

  state_e state_q, state_d, dec_state;
  logic   illegal_q, illegal_d;

  logic             funct_ok;
  logic [ALU_W-1:0] funct_alu;

  logic             pcen_c, irwrite_c, regwrite_c, memwrite_c;
  logic             iord_c, memtoreg_c, regdst_c, alusrca_c;
  logic [1:0]       alusrcb_c, pcsrc_c;
  logic [ALU_W-1:0] alucontrol_c;

  // While reset is held, the outputs show FETCH so that no interrupted access leaks out.
  assign dec_state = reset ? S_FETCH : state_q;

  // R-type funct field to ALU operation.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (dp_io.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = dec_state;
    illegal_d    = illegal_q;
    pcen_c       = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    memwrite_c   = 1'b0;
    iord_c       = 1'b0;
    memtoreg_c   = 1'b0;
    regdst_c     = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = ALU_ADD;

    case (dec_state)
      S_FETCH: begin
        alusrcb_c = 2'b01;
        irwrite_c = dp_io.mem_ready;
        pcen_c    = dp_io.mem_ready;
        if (dp_io.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (dp_io.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (dp_io.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (dp_io.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (dp_io.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        if (funct_ok) alucontrol_c = funct_alu;
        state_d = funct_ok ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        pcen_c       = dp_io.zero;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_HALT) illegal_d = 1'b1;

    if (reset) begin
      pcen_c     = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      memwrite_c = 1'b0;
    end
  end

  assign dp_io.pcen       = pcen_c;
  assign dp_io.irwrite    = irwrite_c;
  assign dp_io.regwrite   = regwrite_c;
  assign dp_io.memwrite   = memwrite_c;
  assign dp_io.iord       = iord_c;
  assign dp_io.memtoreg   = memtoreg_c;
  assign dp_io.regdst     = regdst_c;
  assign dp_io.alusrca    = alusrca_c;
  assign dp_io.alusrcb    = alusrcb_c;
  assign dp_io.pcsrc      = pcsrc_c;
  assign dp_io.alucontrol = alucontrol_c;
  assign dp_io.illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller. The stimulus walks each
// instruction through its phase sequence and queues the expected outputs for every cycle.
module tb_multicycle_controller;
  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXECUTE,
    P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_HALT
  } ph_t;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } vec_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if ifc ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .dp_io (ifc)
  );

  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic ill_s  = 1'b0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // Expected outputs for one cycle in a given phase of an instruction.
  function automatic vec_t model(input ph_t ph, input logic mr, input logic z,
                                 input logic [5:0] f, input logic rst, input logic ill);
    vec_t v;
    ph_t  p;
    int   a;
    v            = '0;
    v.alucontrol = 3'b010;
    v.illegal    = ill;
    p            = rst ? P_FETCH : ph;
    case (p)
      P_FETCH:   begin v.alusrcb = 2'b01; v.irwrite = mr; v.pcen = mr; end
      P_DECODE:  v.alusrcb = 2'b11;
      P_MEMADR:  begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
      P_MEMRD:   v.iord = 1'b1;
      P_MEMWB:   begin v.memtoreg = 1'b1; v.regwrite = 1'b1; end
      P_MEMWR:   begin v.iord = 1'b1; v.memwrite = 1'b1; end
      P_EXECUTE: begin
        v.alusrca = 1'b1;
        a = alu_of(f);
        if (a >= 0) v.alucontrol = 3'(a);
      end
      P_ALUWB:   begin v.regdst = 1'b1; v.regwrite = 1'b1; end
      P_BRANCH:  begin v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = z; end
      P_ADDIEX:  begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
      P_ADDIWB:  v.regwrite = 1'b1;
      P_JUMP:    begin v.pcsrc = 2'b10; v.pcen = 1'b1; end
      default:   ;
    endcase
    if (rst) begin
      v.pcen = 1'b0; v.irwrite = 1'b0; v.regwrite = 1'b0; v.memwrite = 1'b0;
    end
    return v;
  endfunction

  function automatic vec_t got_vec();
    vec_t g;
    g.pcen       = ifc.pcen;
    g.irwrite    = ifc.irwrite;
    g.regwrite   = ifc.regwrite;
    g.memwrite   = ifc.memwrite;
    g.iord       = ifc.iord;
    g.memtoreg   = ifc.memtoreg;
    g.regdst     = ifc.regdst;
    g.alusrca    = ifc.alusrca;
    g.alusrcb    = ifc.alusrcb;
    g.pcsrc      = ifc.pcsrc;
    g.alucontrol = ifc.alucontrol;
    g.illegal    = ifc.illegal;
    return g;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic step(input ph_t ph, input logic mr, input logic z, input logic rst);
    @(posedge clk);
    #1;
    ifc.mem_ready = mr;
    ifc.zero      = z;
    reset         = rst;
    if (ph == P_HALT) ill_s = 1'b1;
    exp_q.push_back(model(ph, mr, z, ifc.funct, rst, ill_s));
    if (rst) ill_s = 1'b0;
  endtask

  task automatic fetch();
    int w = $urandom_range(0, 2);
    repeat (w) step(P_FETCH, 1'b0, rb(), 1'b0);
    step(P_FETCH, 1'b1, rb(), 1'b0);
  endtask

  task automatic mem_wait(input ph_t ph, input int w);
    repeat (w) step(ph, 1'b0, rb(), 1'b0);
    step(ph, 1'b1, rb(), 1'b0);
  endtask

  // Stay halted with random inputs, then release with reset.
  task automatic halt_seq(input int n);
    repeat (n) begin
      step(P_HALT, rb(), rb(), 1'b0);
      ifc.op    = 6'($urandom);
      ifc.funct = 6'($urandom);
    end
    step(P_HALT, rb(), rb(), 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int mw, input int halt_n, input int bz);
    logic z;
    ifc.op    = op;
    ifc.funct = f;
    fetch();
    step(P_DECODE, rb(), rb(), 1'b0);
    case (op)
      OP_LW:   begin step(P_MEMADR, rb(), rb(), 1'b0); mem_wait(P_MEMRD, mw); step(P_MEMWB, rb(), rb(), 1'b0); end
      OP_SW:   begin step(P_MEMADR, rb(), rb(), 1'b0); mem_wait(P_MEMWR, mw); end
      OP_RTYP: begin
        step(P_EXECUTE, rb(), rb(), 1'b0);
        if (alu_of(f) >= 0) step(P_ALUWB, rb(), rb(), 1'b0);
        else halt_seq(halt_n);
      end
      OP_BEQ:  begin
        z = (bz < 0) ? rb() : 1'(bz);
        step(P_BRANCH, rb(), z, 1'b0);
      end
      OP_ADDI: begin step(P_ADDIEX, rb(), rb(), 1'b0); step(P_ADDIWB, rb(), rb(), 1'b0); end
      OP_J:    step(P_JUMP, rb(), rb(), 1'b0);
      default: halt_seq(halt_n);
    endcase
  endtask

  // Monitor: pop and compare one expected vector per cycle.
  always @(negedge clk) begin
    vec_t e, g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got=%b required=%b", $time, g, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl [5];
    logic [5:0] op, f;
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
    fl[3] = 6'b100101; fl[4] = 6'b101010;
    ifc.op = OP_LW; ifc.funct = 6'b100000; ifc.zero = 1'b0; ifc.mem_ready = 1'b0;

    step(P_FETCH, 1'b1, 1'b0, 1'b1);
    step(P_FETCH, 1'b0, 1'b1, 1'b1);

    run_instr(OP_LW,   6'b000000, 0, 0, -1);
    run_instr(OP_SW,   6'b000000, 3, 0, -1);
    run_instr(OP_BEQ,  6'b000000, 0, 0, 1);
    run_instr(OP_BEQ,  6'b000000, 0, 0, 0);
    run_instr(OP_RTYP, 6'b100010, 0, 0, -1);
    run_instr(OP_ADDI, 6'b000000, 0, 0, -1);
    run_instr(OP_J,    6'b000000, 0, 0, -1);
    run_instr(OP_RTYP, 6'b000000, 0, 5, -1);
    run_instr(6'b111111, 6'b000000, 0, 20, -1);

    // Reset arriving while a store waits on memory.
    ifc.op = OP_SW;
    fetch();
    step(P_DECODE, rb(), rb(), 1'b0);
    step(P_MEMADR, rb(), rb(), 1'b0);
    step(P_MEMWR, 1'b0, rb(), 1'b0);
    step(P_MEMWR, 1'b0, rb(), 1'b0);
    step(P_MEMWR, 1'b0, rb(), 1'b1);

    for (int i = 0; i < 150; i++) begin
      f = fl[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYP;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: begin
          op = 6'($urandom);
          if (op == OP_LW || op == OP_SW || op == OP_RTYP || op == OP_BEQ ||
              op == OP_ADDI || op == OP_J) op = 6'b111111;
        end
        default: begin op = OP_RTYP; f = 6'($urandom); end
      endcase
      run_instr(op, f, $urandom_range(0, 3), $urandom_range(1, 5), -1);
    end

    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0 entries left", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
